// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial adder using one 4-bit slice reused per nibble
// A three-state FSM accepts an operand set, adds one nibble per cycle, then holds the result.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 c_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 c_out,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_HOLD} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_psum;
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic            r_cout;
  logic [CW-1:0]   r_cnt;
  logic [4:0]      w_slice;
  logic [W-1:0]    w_psum_nxt;
  logic            w_last;

  assign w_slice    = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0000, r_carry};
  // Each slice result enters at the MSB end so the LSB nibble ends up lowest after NIBBLES shifts.
  assign w_psum_nxt = (r_psum >> 4) | (W'(w_slice[3:0]) << (W - 4));
  assign w_last     = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_ADD;
      S_ADD:   if (w_last)    w_state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    busy      = (r_state == S_ADD);
    out_valid = (r_state == S_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_psum  <= '0;
            r_cnt   <= '0;
          end
        end
        S_ADD: begin
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_psum  <= w_psum_nxt;
          r_carry <= w_slice[4];
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum  <= w_psum_nxt;
            r_cout <= w_slice[4];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum   = r_sum;
  assign c_out = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder at NIBBLES=4 and 2
// Shared stimulus is steered to one DUT at a time; expected values come from plain integer addition.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst;
  logic        sel2;
  logic        t_valid;
  logic        t_ready;
  logic [15:0] t_a;
  logic [15:0] t_b;
  logic        t_cin;

  logic        in_ready4, out_valid4, c_out4, busy4;
  logic [15:0] sum4;
  logic        in_ready2, out_valid2, c_out2, busy2;
  logic [7:0]  sum2;
  logic        w_valid4, w_valid2;
  logic        m_ov, m_ir, m_busy, m_cout;
  logic [15:0] m_sum;

  int checks;
  int passed;

  assign w_valid4 = t_valid & ~sel2;
  assign w_valid2 = t_valid & sel2;
  assign m_ov   = sel2 ? out_valid2 : out_valid4;
  assign m_ir   = sel2 ? in_ready2  : in_ready4;
  assign m_busy = sel2 ? busy2      : busy4;
  assign m_cout = sel2 ? c_out2     : c_out4;
  assign m_sum  = sel2 ? {8'h00, sum2} : sum4;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(w_valid4), .in_ready(in_ready4),
    .a(t_a), .b(t_b), .c_in(t_cin), .out_valid(out_valid4),
    .out_ready(t_ready), .sum(sum4), .c_out(c_out4), .busy(busy4)
  );

  nibble_serial_adder #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(w_valid2), .in_ready(in_ready2),
    .a(t_a[7:0]), .b(t_b[7:0]), .c_in(t_cin), .out_valid(out_valid2),
    .out_ready(t_ready), .sum(sum2), .c_out(c_out2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

  // Present an operand set in IDLE, then wait (bounded) for out_valid; leaves the block in HOLD.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input bit scramble, input bit rnd_ready,
                       output logic [15:0] s, output logic co, output int lat, output int bc);
    t_a = a; t_b = b; t_cin = cin; t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    lat = 0;
    bc  = 0;
    while (!m_ov && lat < 40) begin
      if (m_busy) bc++;
      if (scramble) begin
        t_a = 16'($urandom); t_b = 16'($urandom); t_cin = 1'($urandom); t_valid = 1'($urandom);
      end
      if (rnd_ready) t_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    t_valid = 1'b0;
    t_ready = 1'b0;
    s  = m_sum;
    co = m_cout;
  endtask

  task automatic release_out();
    t_ready = 1'b1;
    @(negedge clk);
    t_ready = 1'b0;
  endtask

  task automatic test_reset();
    sel2 = 1'b0; t_valid = 1'b0; t_ready = 1'b0; t_a = '0; t_b = '0; t_cin = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready4, out_valid4, busy4, c_out4, sum4, in_ready2, out_valid2, busy2, c_out2, sum2}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_state: got ir4=%b ov4=%b busy4=%b co4=%b sum4=%h ir2=%b ov2=%b busy2=%b co2=%b sum2=%h, required ir=1 others 0",
               in_ready4, out_valid4, busy4, c_out4, sum4, in_ready2, out_valid2, busy2, c_out2, sum2);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] s; logic co; int lat; int bc;
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, s, co, lat, bc);
    checks++;
    if (lat !== 4) $display("FAIL basic_latency: got %0d cycles, required 4", lat);
    else passed++;
    checks++;
    if (bc !== 4) $display("FAIL basic_busy_cycles: got %0d, required 4", bc);
    else passed++;
    checks++;
    if ({co, s} !== {1'b0, 16'h5555}) $display("FAIL basic_sum: got c_out=%b sum=%h, required 0 5555", co, s);
    else passed++;
    release_out();
  endtask

  task automatic test_carry_ripple();
    logic [15:0] s; logic co; int lat; int bc;
    do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, s, co, lat, bc);
    checks++;
    if ({co, s} !== {1'b1, 16'h0000}) $display("FAIL ripple_ffff_0_1: got c_out=%b sum=%h, required 1 0000", co, s);
    else passed++;
    release_out();
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, s, co, lat, bc);
    checks++;
    if ({co, s} !== {1'b1, 16'hFFFF}) $display("FAIL ripple_ffff_ffff_1: got c_out=%b sum=%h, required 1 ffff", co, s);
    else passed++;
    release_out();
  endtask

  task automatic test_backpressure();
    logic [15:0] s; logic co; int lat; int bc;
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, s, co, lat, bc);
    checks++;
    if ({co, s} !== {1'b0, 16'h0100}) $display("FAIL bp_sum: got c_out=%b sum=%h, required 0 0100", co, s);
    else passed++;
    t_a = 16'hAAAA; t_b = 16'h5555; t_cin = 1'b1; t_valid = 1'b1; t_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({m_ov, m_ir, m_cout, m_sum} !== {1'b1, 1'b0, 1'b0, 16'h0100})
        $display("FAIL bp_hold_stable[%0d]: got ov=%b ir=%b c_out=%b sum=%h, required 1 0 0 0100", i, m_ov, m_ir, m_cout, m_sum);
      else passed++;
    end
    t_ready = 1'b1;
    @(negedge clk);
    t_ready = 1'b0;
    t_valid = 1'b0;
    checks++;
    if ({m_ir, m_ov, m_busy, m_sum} !== {1'b1, 1'b0, 1'b0, 16'h0100})
      $display("FAIL bp_release: got ir=%b ov=%b busy=%b sum=%h, required 1 0 0 0100", m_ir, m_ov, m_busy, m_sum);
    else passed++;
  endtask

  task automatic test_mid_reset();
    logic [15:0] s; logic co; int lat; int bc; int seen;
    t_a = 16'h8888; t_b = 16'h8888; t_cin = 1'b0; t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({m_ov, m_ir, m_busy, m_cout, m_sum} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000})
      $display("FAIL midreset_immediate: got ov=%b ir=%b busy=%b c_out=%b sum=%h, required 0 1 0 0 0000", m_ov, m_ir, m_busy, m_cout, m_sum);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_ov) seen++;
    end
    checks++;
    if (seen !== 0) $display("FAIL midreset_no_result: got %0d out_valid cycles, required 0", seen);
    else passed++;
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, s, co, lat, bc);
    checks++;
    if ({co, s} !== {1'b0, 16'h0002}) $display("FAIL midreset_next_op: got c_out=%b sum=%h, required 0 0002", co, s);
    else passed++;
    release_out();
  endtask

  task automatic test_isolation();
    logic [15:0] s; logic co; int lat; int bc;
    do_op(16'h1357, 16'h2468, 1'b1, 1'b1, 1'b1, s, co, lat, bc);
    checks++;
    if ({co, s} !== {1'b0, 16'h37C0}) $display("FAIL isolation_sum: got c_out=%b sum=%h, required 0 37c0", co, s);
    else passed++;
    release_out();
  endtask

  task automatic test_random(input bit two);
    logic [15:0] a; logic [15:0] b; logic cin;
    logic [15:0] s; logic co; int lat; int bc;
    longint mask; longint tot; int n; int w;
    sel2 = two;
    n    = two ? 2 : 4;
    w    = 4 * n;
    mask = (64'd1 << w) - 1;
    @(negedge clk);
    for (int k = 0; k < 500; k++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(a, b, cin, 1'b0, 1'b1, s, co, lat, bc);
      tot = (longint'(a) & mask) + (longint'(b) & mask) + longint'(cin);
      checks++;
      if (lat !== n) $display("FAIL rand_latency n=%0d k=%0d: got %0d, required %0d", n, k, lat, n);
      else passed++;
      checks++;
      if ({co, s} !== {tot[w], 16'(tot & mask)})
        $display("FAIL rand_sum n=%0d k=%0d a=%h b=%h cin=%b: got c_out=%b sum=%h, required %b %h",
                 n, k, a, b, cin, co, s, tot[w], 16'(tot & mask));
      else passed++;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_out();
    end
    sel2 = 1'b0;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_basic();
    test_carry_ripple();
    test_backpressure();
    test_mid_reset();
    test_isolation();
    test_random(1'b0);
    test_random(1'b1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
